seg_dynamic_decode: RTL and testbench

- Receive-side counterpart of the 6-digit dynamic 7-segment driver.
- Monitors the multiplexed sel/seg bus and reconstructs the displayed 20-bit value, decimal points, sign and enable state.
- Used for loopback self-test on the board and as a scoreboard front end in display-path benches.

---
 rtl/seg_dynamic_decode_if.sv | 13 +
 rtl/seg_dynamic_decode.sv | 121 ++++++++++++
 tb/tb_seg_dynamic_decode.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg_dynamic_decode_if.sv
// seg_dynamic_decode_if: multiplexed 7-segment bus plus the reconstructed frame outputs
interface seg_dynamic_decode_if;
  logic [5:0] sel;
  logic [7:0] seg;
  logic [19:0] data;
  logic [5:0] point;
  logic sign;
  logic data_valid;
  logic glyph_err;
  logic disp_off;
  modport master (output sel, seg, input data, point, sign, data_valid, glyph_err, disp_off);
  modport slave (input sel, seg, output data, point, sign, data_valid, glyph_err, disp_off);
endinterface

// File: rtl/seg_dynamic_decode.sv
// seg_dynamic_decode: rebuilds value, points, sign from a 6-digit multiplexed 7-seg bus; CHECK_CONSISTENT_EN adds torn-frame filtering
module seg_dynamic_decode #(
  parameter int SETTLE_CNT = 4,
  parameter logic [23:0] TIMEOUT = 24'd600_000
) (
  input logic sys_clk,
  input logic sys_rst_n,
  seg_dynamic_decode_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CNT + 1);
  typedef enum logic [1:0] {COLLECT, CONVERT, OUTPUT} state_t;
  state_t state;
  logic [5:0] sel_r, sel_p, pnt, cpnt, seen, lmask;
  logic [7:0] seg_r, seg_p;
  logic [CW-1:0] cnt;
  logic [23:0] dig, cdig, tcnt;
  logic [19:0] acc;
  logic [2:0] idx;
  logic [3:0] g_dig;
  logic fsign, ferr, csign, cerr, same, onehot, latch, g_ok, g_minus, pass;
`ifdef CHECK_CONSISTENT_EN
  logic [27:0] cand;
  logic cand_v;
  assign pass = cand_v && cand == {acc, cpnt, csign, cerr};
`else
  assign pass = 1'b1;
`endif
  assign same = {sel_r, seg_r} == {sel_p, seg_p};
  assign onehot = sel_r != 6'd0 && (sel_r & (sel_r - 6'd1)) == 6'd0;
  assign latch = same && onehot && cnt == CW'(SETTLE_CNT - 1);
  assign lmask = latch ? sel_r : 6'd0;
  // glyph to digit; blank and minus give 0, anything unknown flags an error
  always_comb begin
    g_ok = 1'b1;
    g_minus = 1'b0;
    g_dig = 4'd0;
    case (seg_r[6:0])
      7'h40: g_dig = 4'd0;
      7'h79: g_dig = 4'd1;
      7'h24: g_dig = 4'd2;
      7'h30: g_dig = 4'd3;
      7'h19: g_dig = 4'd4;
      7'h12: g_dig = 4'd5;
      7'h02: g_dig = 4'd6;
      7'h78: g_dig = 4'd7;
      7'h00: g_dig = 4'd8;
      7'h10: g_dig = 4'd9;
      7'h3F: g_minus = 1'b1;
      7'h7F: g_dig = 4'd0;
      default: g_ok = 1'b0;
    endcase
  end
  // input registers and settle counter; a latch fires once as the count reaches SETTLE_CNT
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {sel_r, seg_r, sel_p, seg_p, cnt} <= '0;
    else begin
      {sel_r, seg_r, sel_p, seg_p} <= {bus.sel, bus.seg, sel_r, seg_r};
      cnt <= !same ? '0 : cnt == CW'(SETTLE_CNT) ? cnt : cnt + 1'b1;
    end
  // collecting frame buffer; leaving COLLECT snapshots it so later latches start the next frame
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {dig, pnt, seen, fsign, ferr, cdig, cpnt, csign, cerr} <= '0;
    else begin
      for (int i = 0; i < 6; i++)
        if (lmask[i]) begin
          dig[4*i +: 4] <= g_dig;
          pnt[i] <= ~seg_r[7];
        end
      if (state == COLLECT && seen == 6'h3F) begin
        {cdig, cpnt, csign, cerr} <= {dig, pnt, fsign, ferr};
        seen <= lmask;
        fsign <= latch & g_minus;
        ferr <= latch & ~g_ok;
      end else begin
        seen <= seen | lmask;
        fsign <= fsign | (latch & g_minus);
        ferr <= ferr | (latch & ~g_ok);
      end
    end
  // conversion FSM, registered outputs and the display-off timer
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= COLLECT;
      {idx, acc, tcnt} <= '0;
      {bus.data, bus.point, bus.sign, bus.data_valid, bus.glyph_err} <= '0;
      bus.disp_off <= 1'b1;
`ifdef CHECK_CONSISTENT_EN
      {cand, cand_v} <= '0;
`endif
    end else begin
      bus.data_valid <= 1'b0;
      bus.glyph_err <= 1'b0;
      tcnt <= tcnt == TIMEOUT ? tcnt : tcnt + 24'd1;
      if (tcnt == TIMEOUT - 24'd1) bus.disp_off <= 1'b1;
      case (state)
        COLLECT: if (seen == 6'h3F) begin
          state <= CONVERT;
          idx <= 3'd5;
        end
        CONVERT: begin
          acc <= (acc << 3) + (acc << 1) + 20'(cdig[4*idx +: 4]);
          idx <= idx - 3'd1;
          if (idx == 3'd0) state <= OUTPUT;
        end
        default: begin
          state <= COLLECT;
          acc <= '0;
`ifdef CHECK_CONSISTENT_EN
          cand <= {acc, cpnt, csign, cerr};
          cand_v <= 1'b1;
`endif
          if (pass) begin
            {bus.data, bus.point, bus.sign, bus.glyph_err} <= {acc, cpnt, csign, cerr};
            bus.data_valid <= 1'b1;
            bus.disp_off <= 1'b0;
            tcnt <= '0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_seg_dynamic_decode.sv
// tb_seg_dynamic_decode: directed frame vectors plus timeout, reset and consistency sequences
module tb_seg_dynamic_decode;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int p0, lat, k;
`ifdef CHECK_CONSISTENT_EN
  localparam int REPS = 2;
`else
  localparam int REPS = 1;
`endif
  typedef struct packed {
    logic [47:0] segs;
    logic gaps;
    logic [19:0] data;
    logic [5:0] point;
    logic sign;
    logic err;
  } vec_t;
  vec_t v [6];
  seg_dynamic_decode_if bus();
  seg_dynamic_decode #(.SETTLE_CNT(4), .TIMEOUT(24'd1000)) dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.data_valid === 1'b1) pulses <= pulses + 1;
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [5:0] s, input logic [7:0] g, input int n);
    @(negedge clk);
    bus.sel = s;
    bus.seg = g;
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic scan(input logic [47:0] s, input logic gaps, input int hi, input int lo);
    for (int p = hi; p >= lo; p--) begin
      drive(6'(1 << p), s[8*p +: 8], p == 0 ? 1 : 20);
      if (gaps && p > 0) begin
        drive(6'b000011, 8'hC0, 10);
        drive(6'd0, 8'hFF, 10);
      end
    end
  endtask
  task automatic wait_valid(output int l);
    l = 0;
    while (bus.data_valid !== 1'b1 && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask
  task automatic scan_frame(input int i, output int l);
    for (int r = 0; r < REPS; r++) begin
      scan(v[i].segs, v[i].gaps, 5, 0);
      wait_valid(l);
    end
  endtask
  task automatic check_vec(input int i, input int l);
    chk("latency", l, 14);
    chk("data", bus.data, v[i].data);
    chk("point", bus.point, v[i].point);
    chk("sign", bus.sign, v[i].sign);
    chk("glyph_err", bus.glyph_err, v[i].err);
    chk("disp_off_low", bus.disp_off, 0);
  endtask
  initial begin
    v[0] = '{48'hF9A4B0999282, 1'b0, 20'd123456, 6'b000000, 1'b0, 1'b0};
    v[1] = '{48'hFFBFF924B099, 1'b0, 20'd1234, 6'b000100, 1'b1, 1'b0};
    v[2] = '{48'hC0C055C0C0C0, 1'b0, 20'd0, 6'b001000, 1'b0, 1'b1};
    v[3] = '{48'h9080F8829299, 1'b1, 20'd987654, 6'b000000, 1'b0, 1'b0};
    v[4] = '{48'h12C0C0C0F900, 1'b0, 20'd500018, 6'b100001, 1'b0, 1'b0};
    v[5] = '{48'h909090909090, 1'b0, 20'd999999, 6'b000000, 1'b0, 1'b0};
    rst_n = 1'b0;
    bus.sel = 6'd0;
    bus.seg = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data, 0);
    chk("rst_point", bus.point, 0);
    chk("rst_sign", bus.sign, 0);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_glyph_err", bus.glyph_err, 0);
    chk("rst_disp_off", bus.disp_off, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p0 = pulses;
      scan_frame(i, lat);
      check_vec(i, lat);
      repeat (3) @(negedge clk);
      chk("pulses", pulses - p0, 1);
      chk("err_pulse_end", bus.glyph_err, 0);
    end
    scan_frame(0, lat);
    chk("to_valid", bus.data_valid, 1);
    k = 0;
    while (bus.disp_off !== 1'b1 && k < 1100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", k, 1000);
    chk("timeout_hold_data", bus.data, 123456);
    scan_frame(1, lat);
    chk("resume_disp_off", bus.disp_off, 0);
    chk("resume_data", bus.data, 1234);
    drive(6'b000001, v[2].segs[7:0], 20);
    drive(6'b000010, v[2].segs[15:8], 20);
    drive(6'b000100, v[2].segs[23:16], 20);
    drive(6'd0, 8'hFF, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", bus.data, 0);
    chk("mid_rst_point", bus.point, 0);
    chk("mid_rst_sign", bus.sign, 0);
    chk("mid_rst_disp_off", bus.disp_off, 1);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    scan(v[2].segs, 1'b0, 5, 1);
    wait_valid(lat);
    repeat (3) @(negedge clk);
    chk("partial_discarded", pulses - p0, 0);
`ifdef CHECK_CONSISTENT_EN
    scan(v[2].segs, 1'b0, 0, 0);
    wait_valid(lat);
    scan(v[2].segs, 1'b0, 5, 0);
`else
    scan(v[2].segs, 1'b0, 0, 0);
`endif
    wait_valid(lat);
    check_vec(2, lat);
    repeat (3) @(negedge clk);
    chk("post_rst_pulses", pulses - p0, 1);
`ifdef CHECK_CONSISTENT_EN
    p0 = pulses;
    scan(v[3].segs, 1'b0, 5, 0);
    wait_valid(lat);
    repeat (3) @(negedge clk);
    chk("torn_no_pulse", pulses - p0, 0);
    chk("torn_hold_data", bus.data, 0);
    scan(v[3].segs, 1'b0, 5, 0);
    wait_valid(lat);
    chk("second_frame_data", bus.data, 987654);
    repeat (3) @(negedge clk);
    chk("second_frame_pulses", pulses - p0, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
